// File: rtl/mul_pipe_arbiter.sv
// Round-robin arbiter sharing one LAT-stage pipelined 8x8 multiplier among NREQ requesters.
// Optional statistics counters are enabled by defining MUL_ARB_STAT_EN.
module mul_pipe_arbiter #(
  parameter int NREQ    = 4,
  parameter int LAT     = 8,
  parameter int MAX_OUT = 4,
  parameter int IDW     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [7:0]          mul_din1,
  output logic [7:0]          mul_din2,
  input  logic [15:0]         mul_dout,
  output logic                resp_valid,
  output logic [IDW-1:0]      resp_id,
  output logic [15:0]         resp_data,
  output logic                busy
`ifdef MUL_ARB_STAT_EN
  ,
  output logic [15:0]         stat_issue,
  output logic [15:0]         stat_block
`endif
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int SW = IDW + 1;

  logic [IDW-1:0]  ptr;
  logic [CW-1:0]   inflight [NREQ];
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] dec_vec;
  logic            grant;
  logic [IDW-1:0]  gid;
  logic [SW-1:0]   scan_sum;
  logic [IDW-1:0]  scan_idx;

  logic [LAT-1:0]  tag_valid;
  logic [IDW-1:0]  tag_id [LAT];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] && (inflight[i] < CW'(MAX_OUT));
    end
  end

  // Rotating scan from ptr; the first eligible requester wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant    = 1'b0;
    gid      = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr} + SW'(k);
      if (scan_sum >= SW'(NREQ)) begin
        scan_sum = scan_sum - SW'(NREQ);
      end
      scan_idx = scan_sum[IDW-1:0];
      if (!grant && elig[scan_idx]) begin
        grant = 1'b1;
        gid   = scan_idx;
      end
    end
    if (rst) begin
      grant = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    mul_din1  = 8'd0;
    mul_din2  = 8'd0;
    if (grant) begin
      req_ready = NREQ'(1) << gid;
      mul_din1  = req_a[{gid, 3'b000} +: 8];
      mul_din2  = req_b[{gid, 3'b000} +: 8];
    end
  end

  always_comb begin
    dec_vec = '0;
    if (tag_valid[LAT-1]) begin
      dec_vec = NREQ'(1) << tag_id[LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant) begin
      ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + IDW'(1);
    end
  end

  // Increment on handshake, decrement as the result is registered; both at once cancel.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst) begin
        inflight[i] <= '0;
      end else if (req_ready[i] && !dec_vec[i]) begin
        inflight[i] <= inflight[i] + CW'(1);
      end else if (dec_vec[i] && !req_ready[i]) begin
        inflight[i] <= inflight[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
    end else begin
      tag_valid[0] <= grant;
      for (int k = 1; k < LAT; k++) begin
        tag_valid[k] <= tag_valid[k-1];
      end
    end
  end

  // NOTE: ids are qualified by tag_valid, so this data pipeline needs no reset.
  always_ff @(posedge clk) begin
    tag_id[0] <= gid;
    for (int k = 1; k < LAT; k++) begin
      tag_id[k] <= tag_id[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= 16'd0;
    end else if (tag_valid[LAT-1]) begin
      resp_valid <= 1'b1;
      resp_id    <= tag_id[LAT-1];
      resp_data  <= mul_dout;
    end else begin
      resp_valid <= 1'b0;
    end
  end

  assign busy = (|tag_valid) || resp_valid;

`ifdef MUL_ARB_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issue <= 16'd0;
      stat_block <= 16'd0;
    end else begin
      if (grant && stat_issue != 16'hFFFF) begin
        stat_issue <= stat_issue + 16'd1;
      end
      if (!grant && (|req_valid) && stat_block != 16'hFFFF) begin
        stat_block <= stat_block + 16'd1;
      end
    end
  end
`else
  // Statistics hardware is absent in this build.
`endif

endmodule

// File: tb/tb_mul_pipe_arbiter.sv
// Scoreboard bench for mul_pipe_arbiter with a behavioural 8-stage multiplier.
// Stats checks are compiled in only when MUL_ARB_STAT_EN is defined.
module tb_mul_pipe_arbiter;

  localparam int NREQ    = 4;
  localparam int LAT     = 8;
  localparam int MAX_OUT = 4;
  localparam int IDW     = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        mul_din1;
  logic [7:0]        mul_din2;
  logic [15:0]       mul_dout;
  logic              resp_valid;
  logic [IDW-1:0]    resp_id;
  logic [15:0]       resp_data;
  logic              busy;
`ifdef MUL_ARB_STAT_EN
  logic [15:0]       stat_issue;
  logic [15:0]       stat_block;
`endif

  always #5 clk = ~clk;

  mul_pipe_arbiter #(.NREQ(NREQ), .LAT(LAT), .MAX_OUT(MAX_OUT), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .mul_din1   (mul_din1),
    .mul_din2   (mul_din2),
    .mul_dout   (mul_dout),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy)
`ifdef MUL_ARB_STAT_EN
    ,
    .stat_issue (stat_issue),
    .stat_block (stat_block)
`endif
  );

  // Behavioural multiplier: operands in cycle t appear on dout in cycle t+LAT.
  logic [15:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= {8'd0, mul_din1} * {8'd0, mul_din2};
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_dout = mpipe[LAT-1];

  typedef struct {
    int id;
    int data;
    int due;
  } exp_t;

  exp_t sbq[$];
  int   mq_id[$];
  int   mq_due[$];
  int   busy_q[$];
  int   m_ptr;
  int   m_inf [NREQ];
  int   m_issue;
  int   m_block;
  int   exp_prod [NREQ];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input int p);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    exp_prod[i]     = p;
  endtask

  // One clock: check outputs at negedge against the model, then advance the model at posedge.
  task automatic step();
    int  t;
    bit  g;
    int  gi;
    int  idx;
    bit  rst_now;
    @(negedge clk);
    t       = cyc;
    g       = 1'b0;
    gi      = 0;
    rst_now = rst;
    if (rst_now) begin
      check("ready_in_rst", int'(req_ready), 0);
    end else begin
      while (busy_q.size() > 0 && busy_q[0] < t) void'(busy_q.pop_front());
      check("busy", int'(busy), (busy_q.size() > 0) ? 1 : 0);
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (!g && req_valid[idx] && m_inf[idx] < MAX_OUT) begin
          g  = 1'b1;
          gi = idx;
        end
      end
      check("req_ready", int'(req_ready), g ? (1 << gi) : 0);
      if (g) begin
        check("din1", int'(mul_din1), int'(req_a[gi*8 +: 8]));
        check("din2", int'(mul_din2), int'(req_b[gi*8 +: 8]));
        sbq.push_back('{id: gi, data: exp_prod[gi], due: t + LAT + 1});
        mq_id.push_back(gi);
        mq_due.push_back(t + LAT + 1);
        busy_q.push_back(t + LAT + 1);
      end else begin
        check("din_idle", int'({mul_din1, mul_din2}), 0);
      end
    end
    @(posedge clk);
    if (rst_now) begin
      sbq.delete();
      mq_id.delete();
      mq_due.delete();
      busy_q.delete();
      m_ptr   = 0;
      m_issue = 0;
      m_block = 0;
      for (int i = 0; i < NREQ; i++) m_inf[i] = 0;
    end else begin
      if (g) begin
        m_ptr = (gi + 1) % NREQ;
        m_inf[gi]++;
        m_issue++;
      end else if (|req_valid) begin
        m_block++;
      end
      if (mq_due.size() > 0 && mq_due[0] == t + 1) begin
        m_inf[mq_id[0]]--;
        void'(mq_id.pop_front());
        void'(mq_due.pop_front());
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation, on time.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && resp_valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got id=%0d data=%0d expected no response (cycle %0d)",
                 resp_id, resp_data, cyc);
      end else begin
        e = sbq.pop_front();
        check("resp_id", int'(resp_id), e.id);
        check("resp_data", int'(resp_data), e.data);
        check("resp_cycle", cyc, e.due);
      end
    end
  end

  localparam int RR_PROD [NREQ] = '{10, 20, 30, 40};

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    m_ptr     = 0;
    m_issue   = 0;
    m_block   = 0;
    for (int i = 0; i < NREQ; i++) begin
      m_inf[i]    = 0;
      exp_prod[i] = 0;
    end
    run(2);
    rst = 1'b0;
    run(1);

    // Single issue: 12*13 = 156.
    set_req(0, 8'd12, 8'd13, 156);
    req_valid = 4'b0001;
    run(1);
    req_valid = '0;
    run(12);

    // Round-robin with a=i+1, b=10.
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'd10, RR_PROD[i]);
    req_valid = 4'b1111;
    run(16);
    req_valid = '0;
    run(12);

    // Max outstanding: requester 2 alone, 7*9 = 63.
    set_req(2, 8'd7, 8'd9, 63);
    req_valid = 4'b0100;
    run(24);
    req_valid = '0;
    run(12);

    // Boundary operands back-to-back on requester 1.
    set_req(1, 8'hFF, 8'hFF, 16'hFE01);
    req_valid = 4'b0010;
    run(1);
    set_req(1, 8'h00, 8'hFF, 0);
    run(1);
    req_valid = '0;
    run(12);

    // Reset mid-flight: three ops from requester 3 are dropped.
    set_req(3, 8'd5, 8'd6, 30);
    req_valid = 4'b1000;
    run(3);
    req_valid = '0;
    run(1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(12);
    set_req(0, 8'd3, 8'd4, 12);
    req_valid = 4'b0001;
    run(1);
    req_valid = 4'b1000;
    run(6);
    req_valid = '0;
    run(12);

    // Stats window: fresh reset, then 20 cycles of requester 2 alone.
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    set_req(2, 8'd7, 8'd9, 63);
    req_valid = 4'b0100;
    run(20);
    req_valid = '0;
    run(12);
`ifdef MUL_ARB_STAT_EN
    check("stat_issue", int'(stat_issue), m_issue);
    check("stat_block", int'(stat_block), m_block);
    check("stat_sum", int'(stat_issue) + int'(stat_block), 20);
`endif

    check("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_pipe_arbiter.md
Name: mul_pipe_arbiter

Overview:
- Shares one 8-stage pipelined 8x8 unsigned multiplier (ports clk/din1/din2/dout, no enable, no stall) among NREQ requesters.
- Each cycle: selects at most one requester round-robin, drives the operands onto the multiplier, tracks issuer ID and valid bit through a tag pipeline matched to multiplier latency.
- Returns each product tagged with requester ID.
- Sits between the requesting datapath blocks and the multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 8, multiplier latency in cycles: operands on din1/din2 during cycle t appear on dout during cycle t+LAT.
- MAX_OUT, 4, maximum in-flight operations per requester (1..LAT+1).
- IDW, 2, requester ID width; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_a  in  8*NREQ  operand A, requester i in bits [8i+7:8i].
- req_b  in  8*NREQ  operand B, same packing.
- req_ready  out  NREQ  grant; handshake on requester i when req_valid[i] && req_ready[i].
- mul_din1  out  8  to multiplier din1.
- mul_din2  out  8  to multiplier din2.
- mul_dout  in  16  from multiplier dout.
- resp_valid  out  1  registered, one-cycle result pulse.
- resp_id  out  IDW  requester owning resp_data.
- resp_data  out  16  product.
- busy  out  1  high when any tag-pipeline or resp stage is valid.

Behaviour:
- Reset:
  - Clock is clk; reset is rst, synchronous and active-high.
  - rst clears: round-robin pointer to 0, all tag valid bits, all in-flight counters, resp_valid=0, resp_id=0, resp_data=0.
  - req_ready=0 while rst is high.
- Eligibility: requester i is eligible when req_valid[i]=1 and inflight[i] < MAX_OUT.
- Grant:
  - Combinational. Scan starts at pointer p, increasing index mod NREQ; the first eligible requester gets req_ready.
  - At most one req_ready bit is high per cycle.
  - req_ready may depend on req_valid.
  - If no requester is eligible, req_ready=0.
- Operands:
  - mul_din1/mul_din2 = granted requester's req_a/req_b in the grant cycle.
  - With no grant, both are 0.
- Pointer: after a grant to i, p <= (i+1) mod NREQ. With no grant, p holds.
- Tag pipeline:
  - LAT-deep shift register of {valid, id}.
  - Stage 0 is loaded with {grant, granted id} at the grant cycle's edge.
  - Stage LAT-1 aligns with mul_dout.
- Response:
  - When the last tag stage is valid: resp_valid<=1, resp_id<=tag id, resp_data<=mul_dout. Otherwise resp_valid<=0; resp_id/resp_data hold.
  - Handshake in cycle t gives resp_valid in cycle t+LAT+1 (9 for defaults).
  - No backpressure; the consumer must accept every pulse.
- In-flight counters:
  - inflight[i] increments on handshake i and decrements when resp_valid is set for id i.
  - Simultaneous increment and decrement: the count holds.
  - The counter never exceeds MAX_OUT, because grant is gated.
- Throughput: one issue per cycle sustained. Results return in issue order.
- Reset mid-operation:
  - All tags are dropped. The multiplier has no reset, so its stale contents are never reported.
  - resp_valid stays 0 until the first post-reset handshake plus LAT+1.
- Illegal: operands change while req_valid=1 and not granted — permitted, since only the value in the grant cycle is used.

Optional Feature:
- MUL_ARB_STAT_EN defined:
  - Adds outputs stat_issue (16 bit), counting handshakes.
  - Adds stat_block (16 bit), counting cycles where some req_valid is high but no grant occurs.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Single issue:
  - Stimulus: after rst, req 0 valid with a=8'd12, b=8'd13 for one cycle.
  - Response: req_ready[0]=1 that cycle; 9 cycles later resp_valid=1, resp_id=0, resp_data=16'd156; busy low afterwards.
- Round-robin:
  - Stimulus: all 4 requesters valid continuously, a=i+1, b=8'd10.
  - Response: grants in order 0,1,2,3,0,...; responses in the same order with data 10,20,30,40.
- Max outstanding:
  - Stimulus: requester 2 alone, continuously valid with MAX_OUT=4.
  - Response: 4 grants in consecutive cycles, then req_ready[2]=0 until the first response; after that, one grant per response.
- Boundary operands:
  - Stimulus: a=8'hFF, b=8'hFF, then a=0, b=8'hFF back-to-back.
  - Response: resp_data 16'hFE01, then 16'h0000 on consecutive cycles.
- Reset mid-flight:
  - Stimulus: issue 3 operations, assert rst for one cycle at cycle 4.
  - Response: no resp_valid for the 3 dropped ops; counters are 0; a fresh issue returns after 9 cycles.
- Stats (MUL_ARB_STAT_EN):
  - Stimulus: repeat the max-outstanding scenario for 20 cycles.
  - Response: stat_issue and stat_block match the scoreboard, and their sum is 20.
